// File: rtl/majority_pkg.sv
// Shared helpers for the N-channel majority voter.
//   popcount  - number of set bits in a zero-extended channel column
//   maj_bit   - strict majority of the low n bits of a column
//   run_cnt_w - width of a run counter that must reach a given threshold
//   pop_cnt_w - width of a popcount over n channels
package majority_pkg;

  // Upper bound on channel count; columns are zero-extended to this width
  // so the helpers can serve any legal N_CH.
  localparam int unsigned MAX_CH = 64;

  function automatic int unsigned popcount(input logic [MAX_CH-1:0] bits);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      cnt += int'(bits[i]);
    end
    return cnt;
  endfunction

  function automatic logic maj_bit(input logic [MAX_CH-1:0] bits,
                                   input int unsigned        n);
    return popcount(bits) > (n / 2);
  endfunction

  function automatic int unsigned run_cnt_w(input int unsigned thresh);
    return $clog2(thresh + 1);
  endfunction

  function automatic int unsigned pop_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/majority_ch_tracker.sv
// Per-channel disagreement tracker.
//   clk, rst_n  - clock, async active-low reset
//   valid       - a voted sample is accepted this cycle
//   mis         - this channel disagreed with the vote of that sample
//   clr         - synchronous clear of run counter, err_cnt and fault
//   err_cnt     - saturating total mismatch count
//   fault       - sticky; set once FAULT_THRESH consecutive mismatches seen
module majority_ch_tracker
  import majority_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned FAULT_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             mis,
  input  logic             clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fault
);

  localparam int unsigned RUN_W = run_cnt_w(FAULT_THRESH);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(FAULT_THRESH);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FAULT_THRESH - 1);

  logic [RUN_W-1:0] run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= '0;
      err_cnt <= '0;
      fault   <= 1'b0;
    end else if (clr) begin
      run     <= '0;
      err_cnt <= '0;
      fault   <= 1'b0;
    end else if (valid) begin
      if (mis) begin
        if (run != RUN_MAX) begin
          run <= run + 1'b1;
        end
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + 1'b1;
        end
        // Fault appears together with the threshold-th mismatching output.
        if (run >= RUN_LAST) begin
          fault <= 1'b1;
        end
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: rtl/majority_voter_seq.sv
// Registered N-channel bitwise majority voter with disagreement tracking.
//   clk, rst_n - clock, async active-low reset
//   in_valid   - in_data carries a sample this cycle
//   in_data    - channel i at [i*WIDTH +: WIDTH]
//   clr        - synchronous clear of err_cnt, run counters and fault
//   out_valid  - out_data holds a newly voted word (1-cycle latency)
//   out_data   - registered bitwise majority
//   mismatch   - channels that differed from the vote of the last valid sample
//   fault      - sticky per-channel persistent-disagreement flags
//   err_cnt    - per-channel saturating mismatch counts, i at [i*CNT_W +: CNT_W]
module majority_voter_seq
  import majority_pkg::*;
#(
  parameter int unsigned N_CH         = 3,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned FAULT_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic                  clr,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [N_CH-1:0]       mismatch,
  output logic [N_CH-1:0]       fault,
  output logic [N_CH*CNT_W-1:0] err_cnt
);

  if (N_CH < 3 || (N_CH % 2) == 0 || N_CH > MAX_CH) begin : g_bad_nch
    $fatal(1, "majority_voter_seq: N_CH must be odd, >= 3 and <= MAX_CH");
  end
  if (FAULT_THRESH < 1 || FAULT_THRESH > 255) begin : g_bad_thresh
    $fatal(1, "majority_voter_seq: FAULT_THRESH must be in 1..255");
  end

  logic [WIDTH-1:0] vote;
  logic [N_CH-1:0]  mis;

  for (genvar b = 0; b < WIDTH; b++) begin : g_vote
    logic [N_CH-1:0] col;
    always_comb begin
      col = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        col[c] = in_data[c*WIDTH + b];
      end
      vote[b] = maj_bit(MAX_CH'(col), N_CH);
    end
  end

  always_comb begin
    mis = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      mis[c] = (in_data[c*WIDTH +: WIDTH] != vote);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      mismatch  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= vote;
        mismatch <= mis;
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_trk
    majority_ch_tracker #(
      .CNT_W        (CNT_W),
      .FAULT_THRESH (FAULT_THRESH)
    ) u_trk (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (in_valid),
      .mis     (mis[c]),
      .clr     (clr),
      .err_cnt (err_cnt[c*CNT_W +: CNT_W]),
      .fault   (fault[c])
    );
  end

endmodule

// File: doc/majority_voter_seq.md
Name: majority_voter_seq

Overview:
- Registered, parametrised N-channel bitwise majority voter; the generalisation of the 3-input majority gate to N odd channels of WIDTH bits.
- Adds valid qualification, per-channel disagreement tracking, saturating error counters and sticky fault flags.
- Sits after redundant (TMR/NMR) datapath copies. It forwards the voted word and flags channels that persistently disagree.

Parameters:
- N_CH, 3, number of redundant input channels; must be odd and >= 3 (elaboration-time check, fatal otherwise).
- WIDTH, 8, bits per channel word.
- CNT_W, 8, width of each per-channel total-error counter.
- FAULT_THRESH, 4, consecutive mismatching valid samples that latch a channel fault; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is a sample this cycle.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- clr  input  1  synchronous clear of counters and fault flags.
- out_valid  output  1  out_data holds a new voted word.
- out_data  output  WIDTH  registered bitwise-majority result.
- mismatch  output  N_CH  bit i set when channel i differed from the vote of the last valid sample.
- fault  output  N_CH  sticky; bit i set after FAULT_THRESH consecutive mismatches of channel i.
- err_cnt  output  N_CH*CNT_W  per-channel total mismatch count, saturating; channel i at [i*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, mismatch=0, fault=0, err_cnt=0, internal run counters=0.
- Vote (combinational): vote[b]=1 iff popcount(channel bits b) > N_CH/2. Ties are impossible because N_CH is odd.
- Latency: exactly 1 cycle. A sample with in_valid high at edge k gives out_valid=1 and out_data=vote after edge k. No backpressure; the block accepts every cycle.
- When in_valid is low at an edge:
  - out_valid=0.
  - out_data, mismatch, fault, err_cnt and the run counters hold.
- Per channel i, on a valid sample:
  - mis_i = (channel i word != vote).
  - mismatch[i] <= mis_i.
  - If mis_i: run_i increments, saturating at FAULT_THRESH. err_cnt_i increments, saturating at 2^CNT_W-1 with no wrap.
  - If not mis_i: run_i <= 0, and err_cnt_i holds.
  - fault[i] sets on the edge where run_i reaches FAULT_THRESH, so it is visible with the FAULT_THRESH-th mismatching out_valid. Once set, it stays set until clr or reset, even after the channel agrees again.
- clr (synchronous):
  - Zeroes err_cnt, run counters and fault at the next edge.
  - If in_valid is high in the same cycle, clr takes priority for counters and fault. The vote, out_valid, out_data and mismatch still update from the sample.
  - Counting resumes with the following sample.
- Minority edge cases:
  - Several channels may be wrong at once. Each is tracked independently.
  - When more than N_CH/2 channels are wrong, the vote follows the majority and the correct channels are flagged as mismatching. This is intended; there is no ground-truth detection.
- Reset asserted mid-stream: all state is cleared immediately and asynchronously. The first sample after release behaves as the first sample ever.
- Width rules: run counter width is clog2(FAULT_THRESH+1). popcount width is clog2(N_CH+1).

Decomposition:
- Package majority_pkg:
  - function popcount(N_CH-bit slice).
  - function maj_bit(slice) returning popcount > N_CH/2.
  - localparam helpers for run counter width.
- Sub-module majority_ch_tracker, instantiated N_CH times:
  - Inputs: valid, mis, clr.
  - Holds the run counter, saturating err_cnt and sticky fault.
- The top level holds the bitwise vote (generate over WIDTH) and the output registers.

Test Plan:
- Defaults (N_CH=3, WIDTH=8). Valid sample ch0=0xA5, ch1=0xA5, ch2=0xA5 -> next cycle out_valid=1, out_data=0xA5, mismatch=000, err_cnt all 0.
- Bitwise vote: ch0=0xF0, ch1=0xCC, ch2=0xAA -> out_data=0xE8. All three channels flagged: mismatch=111, each err_cnt=1.
- Fault latch: ch2 differs on 4 consecutive valid samples (with in_valid gaps in between) -> fault[2]=1 after the 4th. Then 3 mismatches, 1 agree, 3 mismatches on ch1 -> fault[1] stays 0.
- Saturation and clr:
  - CNT_W=2, ch0 differs on 5 samples -> err_cnt0=3, held.
  - clr with a concurrent valid sample -> err_cnt=0, fault=0, out_data still updated.
- N_CH=5, WIDTH=4: inputs 0x1,0x1,0x1,0x6,0x7 -> out_data=0x1, mismatch=11000 (bits 4,3 set).
- Async reset: assert rst_n=0 between clock edges mid-stream -> all outputs 0 immediately. After release, the first valid sample yields correct data with counters starting at 0.
